// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a byte-wide register file. All SPI pins are oversampled in the
// system clock domain; byte 0 is the command (bit7 = read), then auto-incrementing data bytes.
module spi_slave_regfile #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              SPI_SCLK,
  input  logic              SPI_CSN,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [7:0]        reg_wr_data,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [7:0]        host_rd_data,
  output logic              frame_done,
  output logic              err_short,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  csn_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    sclk_q;
  logic                    csn_q;
  logic                    mosi_q;
  logic [2:0]              bit_cnt;
  logic [6:0]              rx_shift;
  logic [7:0]              tx_shift;
  logic [ADDR_W-1:0]       addr;
  logic [7:0]              regs [DEPTH];

  logic                    sclk_s;
  logic                    csn_s;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    csn_rise;
  logic                    csn_fall;
  logic                    byte_done;
  logic [7:0]              rx_byte;

  // Edge detection on the synchronized pins; MOSI is taken from its edge-detect flop.
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign csn_rise  = csn_s & ~csn_q;
  assign csn_fall  = ~csn_s & csn_q;
  assign rx_byte   = {rx_shift, mosi_q};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  assign SPI_MISO     = tx_shift[7];
  assign host_rd_data = regs[host_rd_addr];

  always_ff @(posedge sclk) begin
    if (rst) begin
      sclk_sync   <= '0;
      csn_sync    <= '0;
      mosi_sync   <= '0;
      sclk_q      <= 1'b0;
      csn_q       <= 1'b0;
      mosi_q      <= 1'b0;
      state       <= IDLE;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      addr        <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], SPI_CSN};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      sclk_q    <= sclk_s;
      csn_q     <= csn_s;
      mosi_q    <= mosi_sync[SYNC_STAGES-1];

      reg_wr_en  <= 1'b0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;

      if (csn_rise) begin
        // End of frame from any state; a partial byte is dropped and flagged.
        state    <= IDLE;
        busy     <= 1'b0;
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        if (bit_cnt != 3'd0) err_short <= 1'b1;
        else if (state == WR || state == RD) frame_done <= 1'b1;
      end else if (state == IDLE) begin
        if (csn_fall) begin
          state    <= CMD;
          busy     <= 1'b1;
          bit_cnt  <= '0;
          rx_shift <= '0;
        end
      end else begin
        if (sclk_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_byte[6:0];
        end
        if (byte_done) begin
          case (state)
            CMD: begin
              addr <= rx_byte[ADDR_W-1:0];
              if (rx_byte[7]) begin
                state    <= RD;
                tx_shift <= regs[rx_byte[ADDR_W-1:0]];
              end else begin
                state <= WR;
              end
            end
            WR: begin
              reg_wr_en     <= 1'b1;
              reg_wr_addr   <= addr;
              reg_wr_data   <= rx_byte;
              regs[addr]    <= rx_byte;
              addr          <= addr + ADDR_W'(1);
            end
            RD: begin
              tx_shift <= regs[addr + ADDR_W'(1)];
              addr     <= addr + ADDR_W'(1);
            end
            default: ;
          endcase
        end else if (state == RD && sclk_fall && bit_cnt != 3'd0) begin
          // The fall right after a reload keeps bit7 on the pin for the master's next rise.
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

endmodule
